// File: rtl/uart_frame_ctrl.sv
// Parses SYNC/BASE/LEN/payload/CHK write frames from a UART byte stream and commits good frames.
// Latency: first write valid one cycle after the CHK byte; one write per accepted handshake.
// Backpressure: write outputs hold while i_Wr_Ready is low; bytes arriving during commit are dropped.
module uart_frame_ctrl #(
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT_CLKS = 20000,
    parameter int ADDR_W       = 8
) (
    input  logic              i_Clock,
    input  logic              i_Rst_n,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Wr_Valid,
    input  logic              i_Wr_Ready,
    output logic [ADDR_W-1:0] o_Wr_Addr,
    output logic [7:0]        o_Wr_Data,
    output logic              o_Busy,
    output logic              o_Frame_Done,
    output logic              o_Err,
    output logic [1:0]        o_Err_Code
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] ERR_CHK = 2'b01;
    localparam logic [1:0] ERR_LEN = 2'b10;
    localparam logic [1:0] ERR_TO  = 2'b11;

    typedef enum logic [2:0] {
        HUNT,
        GET_BASE,
        GET_LEN,
        GET_DATA,
        GET_CHK,
        COMMIT,
        DONE
    } state_t;

    state_t          state;
    logic [7:0]      base;
    logic [7:0]      len;
    logic [7:0]      idx;
    logic [7:0]      acc;
    logic [TW-1:0]   to_cnt;
    logic [7:0]      pay_buf [0:MAX_LEN-1];

    logic            in_frame;
    logic            expired;
    logic            last_wr;
    logic [IW-1:0]   wr_ix;
    logic [IW-1:0]   nxt_ix;

    assign in_frame = (state == GET_BASE) || (state == GET_LEN) ||
                      (state == GET_DATA) || (state == GET_CHK);
    // A byte landing in the expiry cycle takes priority over the timeout.
    assign expired  = in_frame && !i_Rx_DV && (to_cnt == TO_LAST);
    assign last_wr  = (idx == len - 8'd1);
    assign wr_ix    = idx[IW-1:0];
    assign nxt_ix   = IW'(idx + 8'd1);

    // Payload storage needs no reset; it is always rewritten before being read.
    always_ff @(posedge i_Clock) begin
        if (state == GET_DATA && i_Rx_DV) begin
            pay_buf[wr_ix] <= i_Rx_Byte;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state        <= HUNT;
            base         <= 8'd0;
            len          <= 8'd0;
            idx          <= 8'd0;
            acc          <= 8'd0;
            to_cnt       <= '0;
            o_Wr_Valid   <= 1'b0;
            o_Wr_Addr    <= '0;
            o_Wr_Data    <= 8'd0;
            o_Busy       <= 1'b0;
            o_Frame_Done <= 1'b0;
            o_Err        <= 1'b0;
            o_Err_Code   <= 2'b00;
        end else begin
            o_Err        <= 1'b0;
            o_Frame_Done <= 1'b0;

            if (in_frame && !i_Rx_DV) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end

            if (expired) begin
                state      <= HUNT;
                o_Busy     <= 1'b0;
                o_Err      <= 1'b1;
                o_Err_Code <= ERR_TO;
            end else begin
                case (state)
                    HUNT: begin
                        if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
                            state  <= GET_BASE;
                            o_Busy <= 1'b1;
                        end
                    end
                    GET_BASE: begin
                        if (i_Rx_DV) begin
                            base  <= i_Rx_Byte;
                            acc   <= i_Rx_Byte;
                            state <= GET_LEN;
                        end
                    end
                    GET_LEN: begin
                        if (i_Rx_DV) begin
                            if (i_Rx_Byte == 8'd0 || i_Rx_Byte > 8'(MAX_LEN)) begin
                                state      <= HUNT;
                                o_Busy     <= 1'b0;
                                o_Err      <= 1'b1;
                                o_Err_Code <= ERR_LEN;
                            end else begin
                                len   <= i_Rx_Byte;
                                acc   <= acc ^ i_Rx_Byte;
                                idx   <= 8'd0;
                                state <= GET_DATA;
                            end
                        end
                    end
                    GET_DATA: begin
                        if (i_Rx_DV) begin
                            acc <= acc ^ i_Rx_Byte;
                            idx <= idx + 8'd1;
                            if (last_wr) begin
                                state <= GET_CHK;
                            end
                        end
                    end
                    GET_CHK: begin
                        if (i_Rx_DV) begin
                            if (i_Rx_Byte == acc) begin
                                idx        <= 8'd0;
                                state      <= COMMIT;
                                o_Wr_Valid <= 1'b1;
                                o_Wr_Addr  <= ADDR_W'(base);
                                o_Wr_Data  <= pay_buf[0];
                            end else begin
                                state      <= HUNT;
                                o_Busy     <= 1'b0;
                                o_Err      <= 1'b1;
                                o_Err_Code <= ERR_CHK;
                            end
                        end
                    end
                    COMMIT: begin
                        if (i_Wr_Ready) begin
                            if (last_wr) begin
                                o_Wr_Valid   <= 1'b0;
                                o_Frame_Done <= 1'b1;
                                state        <= DONE;
                            end else begin
                                idx       <= idx + 8'd1;
                                o_Wr_Addr <= ADDR_W'(base) + ADDR_W'(idx) + ADDR_W'(1);
                                o_Wr_Data <= pay_buf[nxt_ix];
                            end
                        end
                    end
                    DONE: begin
                        state  <= HUNT;
                        o_Busy <= 1'b0;
                    end
                    default: begin
                        state  <= HUNT;
                        o_Busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
Sequencer that consumes the byte stream from the UART receiver (data-valid pulse plus byte) and parses framed write commands. Payload bytes go into an internal buffer. Only a frame whose checksum passes is committed to a downstream register/memory write port, one byte per valid/ready handshake. Bad, truncated or stalled frames are discarded and flagged with an error code.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame; buffer depth; range 1..255
TIMEOUT_CLKS, 20000, i_Clock cycles allowed between consecutive bytes inside a frame
ADDR_W, 8, width of the write address port; ADDR_W >= 8

Ports:
i_Clock  in  1  system clock, all logic on rising edge
i_Rst_n  in  1  asynchronous active-low reset
i_Rx_DV  in  1  one-cycle pulse: i_Rx_Byte valid (from UART receiver)
i_Rx_Byte  in  8  received byte
o_Wr_Valid  out  1  write request valid
i_Wr_Ready  in  1  downstream accepts write when high with o_Wr_Valid
o_Wr_Addr  out  ADDR_W  write address
o_Wr_Data  out  8  write data
o_Busy  out  1  high in any state other than HUNT
o_Frame_Done  out  1  one-cycle pulse after last committed write
o_Err  out  1  one-cycle pulse on frame rejection
o_Err_Code  out  2  01 checksum, 10 bad length, 11 timeout; held until next o_Err

Behaviour:
- Frame format: SYNC=0xA5, BASE, LEN, LEN payload bytes, CHK. CHK = XOR of BASE, LEN and all payload bytes.
- Reset (async, i_Rst_n low): state=HUNT. All outputs 0. Byte counter, checksum accumulator and timeout counter cleared. Buffer contents don't care. Reset mid-frame or mid-commit abandons the frame with no pulses.
- States: HUNT, GET_BASE, GET_LEN, GET_DATA, GET_CHK, COMMIT, DONE.
- HUNT: on i_Rx_DV with byte 0xA5 -> GET_BASE. Any other byte is ignored.
- GET_BASE: on i_Rx_DV, latch BASE, acc=BASE -> GET_LEN.
- GET_LEN: on i_Rx_DV:
  - LEN==0 or LEN>MAX_LEN -> o_Err, code 10 -> HUNT.
  - Otherwise latch LEN, acc^=LEN, idx=0 -> GET_DATA.
- GET_DATA: on i_Rx_DV, buf[idx]=byte, acc^=byte, idx++. When idx reaches LEN -> GET_CHK.
- GET_CHK: on i_Rx_DV:
  - byte==acc -> COMMIT with idx=0.
  - Otherwise o_Err, code 01 -> HUNT. No writes are issued.
- Timeout: a counter runs in GET_BASE..GET_CHK, is cleared on every i_Rx_DV and on state entry. When the count reaches TIMEOUT_CLKS-1 with no byte: o_Err, code 11 -> HUNT. A byte arriving in the same cycle as expiry wins; no timeout.
- COMMIT:
  - o_Wr_Valid=1, o_Wr_Addr = zero-extended BASE + idx (modulo 2^ADDR_W), o_Wr_Data = buf[idx].
  - Outputs stay stable while i_Wr_Ready=0. On o_Wr_Valid&i_Wr_Ready, idx++.
  - After the write with idx==LEN-1 is accepted: o_Wr_Valid=0 next cycle -> DONE.
  - First o_Wr_Valid appears the cycle after the CHK byte's i_Rx_DV.
- DONE: o_Frame_Done=1 for one cycle -> HUNT.
- Bytes arriving during COMMIT/DONE are dropped, including 0xA5. No error is raised; the UART sender must pace frames.
- o_Err and o_Frame_Done are registered single-cycle pulses and never assert together. o_Err_Code updates in the same cycle o_Err asserts.
- i_Rx_DV is assumed to be a single-cycle pulse. Consecutive-cycle pulses are each treated as separate bytes.
- Widths: idx and LEN counters are 8 bits. The checksum accumulator is 8 bits.

Test Plan:
- Good frame A5 10 03 11 22 33 CHK=0x13 (i_Wr_Ready=1) -> writes (0x10,0x11),(0x11,0x22),(0x12,0x33) on 3 consecutive cycles, then one o_Frame_Done pulse, o_Err never high.
- Same frame with CHK=0x14 -> o_Err with code 01 one cycle after CHK DV, zero o_Wr_Valid cycles, back in HUNT (o_Busy=0).
- A5 00 00 and A5 00 11 (MAX_LEN=16) -> o_Err with code 10 each time, no writes; a following good frame commits normally.
- A5 20, then silence for TIMEOUT_CLKS cycles -> o_Err with code 11 exactly TIMEOUT_CLKS cycles after last DV; a byte at cycle TIMEOUT_CLKS-1 instead -> no error.
- Good frame with BASE=0xFE, LEN=3, i_Wr_Ready toggling 0/1 -> addresses FE, FF, 00 (wrap at ADDR_W=8), address/data held stable while not ready; bytes injected during COMMIT are ignored.
- Assert i_Rst_n low mid-GET_DATA and mid-COMMIT -> all outputs 0 immediately, HUNT, no pulses; next frame parses correctly.
